// File: rtl/victim_cache_ctrl_pkg.sv
// Shared types for the victim-cache controller: tags, way/age indices, bursts, FSM states.
package victim_cache_ctrl_pkg;

  localparam int TAG_WIDTH   = 12;
  localparam int OFFSET_BITS = 4;
  localparam int NUM_WAYS    = 4;

  typedef logic [TAG_WIDTH-1:0] lc3b_vc_tag;
  typedef logic [1:0]           lc3b_vc_way;
  typedef logic [1:0]           lc3b_vc_age;
  typedef logic [127:0]         lc3b_burst;
  typedef logic [15:0]          lc3b_word;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITEBACK,
    S_INSERT,
    S_RESPOND
  } vc_state_e;

  function automatic lc3b_vc_tag addr_tag(input lc3b_word addr);
    return addr[15:OFFSET_BITS];
  endfunction

endpackage

// File: rtl/vc_lru.sv
// Four 2-bit age counters (0 = MRU, 3 = LRU); a touch makes one way MRU and ages the younger ones.
module vc_lru
  import victim_cache_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       touch,
  input  lc3b_vc_way way,
  output lc3b_vc_way lru_way
);

  lc3b_vc_age age_q [NUM_WAYS];
  lc3b_vc_age age_d [NUM_WAYS];

  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) begin
      age_d[i] = age_q[i];
    end
    if (touch) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (lc3b_vc_way'(i) == way) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[way]) begin
          age_d[i] = age_q[i] + 2'd1;
        end
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (age_q[i] == 2'd3) lru_way = lc3b_vc_way'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WAYS; i++) age_q[i] <= lc3b_vc_age'(i);
    end else begin
      for (int i = 0; i < NUM_WAYS; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: rtl/victim_cache_ctrl.sv
// Tag/valid/dirty store and sequencing FSM for the 4-way fully-associative victim cache.
//   state     | meaning
//   IDLE      | waiting for l1_req
//   CHECK     | tag lookup, latch response, pick slot
//   WRITEBACK | dirty victim to memory until pmem_resp
//   INSERT    | write L1 evictee into slot
//   RESPOND   | one-cycle l1_resp
module victim_cache_ctrl
  import victim_cache_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         l1_req,
  input  logic [15:0]  l1_addr,
  input  logic         l1_evict_valid,
  input  logic [15:0]  l1_evict_addr,
  input  logic         l1_evict_dirty,
  input  logic [127:0] l1_evict_data,
  output logic         l1_resp,
  output logic         l1_hit,
  output logic         l1_hit_dirty,
  output logic [127:0] l1_rdata,
  output logic         dar_load,
  output logic [1:0]   dar_way,
  output logic [127:0] dar_data_in,
  input  logic [127:0] dar_out_a,
  input  logic [127:0] dar_out_b,
  input  logic [127:0] dar_out_c,
  input  logic [127:0] dar_out_d,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp
);

  vc_state_e           state_q, state_d;
  logic [NUM_WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  lc3b_vc_tag          tag_q [NUM_WAYS];
  lc3b_vc_tag          tag_d [NUM_WAYS];
  lc3b_vc_way          slot_q, slot_d;
  logic                hit_q, hit_d, hit_dirty_q, hit_dirty_d;
  lc3b_burst           rdata_q, rdata_d;

  lc3b_burst  way_data [NUM_WAYS];
  lc3b_vc_tag req_tag, ev_tag;
  logic       hit, ev_match, free_avail;
  lc3b_vc_way hit_way, ev_way, free_way, lru_way, slot_sel;
  logic       unused_offsets;

  assign way_data[0]    = dar_out_a;
  assign way_data[1]    = dar_out_b;
  assign way_data[2]    = dar_out_c;
  assign way_data[3]    = dar_out_d;
  assign req_tag        = addr_tag(l1_addr);
  assign ev_tag         = addr_tag(l1_evict_addr);
  assign unused_offsets = ^{l1_addr[OFFSET_BITS-1:0], l1_evict_addr[OFFSET_BITS-1:0]};

  // Descending scan so the lowest-index match wins.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    ev_match   = 1'b0;
    ev_way     = '0;
    free_avail = 1'b0;
    free_way   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == req_tag) begin
        hit     = 1'b1;
        hit_way = lc3b_vc_way'(i);
      end
      if (valid_q[i] && tag_q[i] == ev_tag) begin
        ev_match = 1'b1;
        ev_way   = lc3b_vc_way'(i);
      end
      if (!valid_q[i]) begin
        free_avail = 1'b1;
        free_way   = lc3b_vc_way'(i);
      end
    end
    if (l1_evict_valid && hit) slot_sel = hit_way;
    else if (ev_match)         slot_sel = ev_way;
    else if (free_avail)       slot_sel = free_way;
    else                       slot_sel = lru_way;
  end

  vc_lru u_lru (
    .clk     (clk),
    .rst     (reset),
    .touch   (state_q == S_INSERT),
    .way     (slot_q),
    .lru_way (lru_way)
  );

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    slot_d       = slot_q;
    hit_d        = hit_q;
    hit_dirty_d  = hit_dirty_q;
    rdata_d      = rdata_q;
    l1_resp      = 1'b0;
    dar_load     = 1'b0;
    dar_way      = '0;
    dar_data_in  = '0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      S_IDLE: if (l1_req) state_d = S_CHECK;
      S_CHECK: begin
        hit_d       = hit;
        hit_dirty_d = hit && dirty_q[hit_way];
        rdata_d     = hit ? way_data[hit_way] : '0;
        slot_d      = slot_sel;
        if (!l1_evict_valid) begin
          // The line moves up to L1, so the victim copy is dropped.
          if (hit) valid_d[hit_way] = 1'b0;
          state_d = S_RESPOND;
        end else if (!hit && !ev_match && valid_q[slot_sel] && dirty_q[slot_sel]) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_INSERT;
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[slot_q], {OFFSET_BITS{1'b0}}};
        pmem_wdata   = way_data[slot_q];
        if (pmem_resp) state_d = S_INSERT;
      end
      S_INSERT: begin
        dar_load         = 1'b1;
        dar_way          = slot_q;
        dar_data_in      = l1_evict_data;
        tag_d[slot_q]    = ev_tag;
        valid_d[slot_q]  = 1'b1;
        dirty_d[slot_q]  = l1_evict_dirty;
        state_d          = S_RESPOND;
      end
      S_RESPOND: begin
        l1_resp = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign l1_hit       = hit_q;
  assign l1_hit_dirty = hit_dirty_q;
  assign l1_rdata     = rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      slot_q      <= '0;
      hit_q       <= 1'b0;
      hit_dirty_q <= 1'b0;
      rdata_q     <= '0;
      for (int i = 0; i < NUM_WAYS; i++) tag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      slot_q      <= slot_d;
      hit_q       <= hit_d;
      hit_dirty_q <= hit_dirty_d;
      rdata_q     <= rdata_d;
      tag_q       <= tag_d;
    end
  end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Self-checking bench: transaction-level cache model (MRU-ordered list) checked cycle by cycle.
module tb_victim_cache_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         l1_req = 1'b0;
  logic [15:0]  l1_addr = '0;
  logic         l1_evict_valid = 1'b0;
  logic [15:0]  l1_evict_addr = '0;
  logic         l1_evict_dirty = 1'b0;
  logic [127:0] l1_evict_data = '0;
  logic         l1_resp, l1_hit, l1_hit_dirty;
  logic [127:0] l1_rdata;
  logic         dar_load;
  logic [1:0]   dar_way;
  logic [127:0] dar_data_in;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
  logic [127:0] dar_mem [4];

  always #5 clk = ~clk;

  always @(posedge clk) if (dar_load) dar_mem[dar_way] <= dar_data_in;

  victim_cache_ctrl dut (
    .clk(clk), .reset(reset),
    .l1_req(l1_req), .l1_addr(l1_addr),
    .l1_evict_valid(l1_evict_valid), .l1_evict_addr(l1_evict_addr),
    .l1_evict_dirty(l1_evict_dirty), .l1_evict_data(l1_evict_data),
    .l1_resp(l1_resp), .l1_hit(l1_hit), .l1_hit_dirty(l1_hit_dirty), .l1_rdata(l1_rdata),
    .dar_load(dar_load), .dar_way(dar_way), .dar_data_in(dar_data_in),
    .dar_out_a(dar_mem[0]), .dar_out_b(dar_mem[1]), .dar_out_c(dar_mem[2]), .dar_out_d(dar_mem[3]),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: contents per way plus recency list, most recently inserted way first.
  bit           m_valid [4];
  bit           m_dirty [4];
  logic [11:0]  m_tag   [4];
  logic [127:0] m_data  [4];
  int           m_order [$];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_order = {0, 1, 2, 3};
  endfunction

  function automatic void model_touch(input int w);
    for (int j = 0; j < m_order.size(); j++) begin
      if (m_order[j] == w) begin
        m_order.delete(j);
        break;
      end
    end
    m_order.push_front(w);
  endfunction

  int           obs_resp_cyc, obs_load_way, obs_wb_cycles;
  logic [15:0]  obs_wb_addr;
  logic         obs_hit, obs_hit_dirty;
  logic [127:0] obs_rdata;

  task automatic run_req(input logic [15:0] addr, input bit ev, input logic [15:0] ev_addr,
                         input bit ev_dirty, input logic [127:0] ev_data, input int d);
    int hw, mw, fw, slot, r_cyc, i_cyc;
    bit wb, exp_hd;
    logic [127:0] exp_rd, exp_wb_data;
    logic [15:0] exp_wb_addr;
    hw = -1; mw = -1; fw = -1;
    for (int i = 0; i < 4; i++) begin
      if (hw < 0 && m_valid[i] && m_tag[i] == addr[15:4]) hw = i;
      if (mw < 0 && m_valid[i] && m_tag[i] == ev_addr[15:4]) mw = i;
      if (fw < 0 && !m_valid[i]) fw = i;
    end
    if (ev && hw >= 0) slot = hw;
    else if (mw >= 0)  slot = mw;
    else if (fw >= 0)  slot = fw;
    else               slot = m_order[3];
    wb          = ev && hw < 0 && mw < 0 && m_valid[slot] && m_dirty[slot];
    r_cyc       = !ev ? 2 : (wb ? 4 + d : 3);
    i_cyc       = ev ? r_cyc - 1 : -1;
    exp_rd      = (hw >= 0) ? m_data[hw] : '0;
    exp_hd      = (hw >= 0) && m_dirty[hw];
    exp_wb_addr = {m_tag[slot], 4'h0};
    exp_wb_data = m_data[slot];

    obs_resp_cyc = -1; obs_load_way = -1; obs_wb_cycles = 0; obs_wb_addr = '0;
    obs_hit = 1'b0; obs_hit_dirty = 1'b0; obs_rdata = '0;
    l1_addr = addr; l1_evict_valid = ev; l1_evict_addr = ev_addr;
    l1_evict_dirty = ev_dirty; l1_evict_data = ev_data;
    l1_req = 1'b1;
    for (int k = 1; k <= r_cyc + 1; k++) begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      check("l1_resp", l1_resp, k == r_cyc);
      check("dar_load", dar_load, k == i_cyc);
      check("pmem_write", pmem_write, wb && k >= 2 && k <= 2 + d);
      if (dar_load) begin
        obs_load_way = dar_way;
        check("dar_way", dar_way, slot);
        check("dar_data_in", dar_data_in, ev_data);
      end
      if (pmem_write) begin
        obs_wb_cycles++;
        obs_wb_addr = pmem_address;
        check("pmem_address", pmem_address, exp_wb_addr);
        check("pmem_wdata", pmem_wdata, exp_wb_data);
      end
      if (l1_resp && obs_resp_cyc < 0) begin
        obs_resp_cyc = k; obs_hit = l1_hit; obs_hit_dirty = l1_hit_dirty; obs_rdata = l1_rdata;
      end
      if (k == r_cyc) begin
        check("l1_hit", l1_hit, hw >= 0);
        check("l1_hit_dirty", l1_hit_dirty, exp_hd);
        check("l1_rdata", l1_rdata, exp_rd);
        l1_req = 1'b0;
      end
      if (wb && k == 2 + d) pmem_resp = 1'b1;
    end
    l1_evict_valid = 1'b0;

    if (!ev && hw >= 0) m_valid[hw] = 0;
    if (ev) begin
      m_tag[slot] = ev_addr[15:4]; m_valid[slot] = 1; m_dirty[slot] = ev_dirty;
      m_data[slot] = ev_data;
      model_touch(slot);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    l1_req = 1'b0; l1_evict_valid = 1'b0; pmem_resp = 1'b0;
    @(posedge clk); #1;
    check("rst l1_resp", l1_resp, 0);
    check("rst l1_hit", l1_hit, 0);
    check("rst l1_rdata", l1_rdata, 0);
    check("rst dar_load", dar_load, 0);
    check("rst pmem_write", pmem_write, 0);
    check("rst pmem_address", pmem_address, 0);
    reset = 1'b0;
    model_reset();
  endtask

  localparam logic [127:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D2 = 128'hAAAA_0000_BBBB_0000_CCCC_0000_DDDD_0001;
  localparam logic [127:0] E2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    logic [15:0] ra, ea;
    model_reset();
    #12;
    do_reset();

    // Empty cache, no evictee
    run_req(16'h1230, 0, 16'h0, 0, '0, 0);
    check("t1 resp cycle", obs_resp_cyc, 2);
    check("t1 hit", obs_hit, 0);
    check("t1 rdata", obs_rdata, 0);
    check("t1 no load", obs_load_way < 0, 1);

    // Fill in order, then LRU replacement of way 0
    for (int i = 0; i < 4; i++) begin
      ea = 16'h1000 * (i + 1);
      run_req(16'h0F00, 1, ea, 0, {4{ea, 16'h0}}, 0);
      check("fill way", obs_load_way, i);
      check("fill resp cycle", obs_resp_cyc, 3);
    end
    run_req(16'h0F00, 1, 16'h5000, 0, D1, 0);
    check("lru replace way", obs_load_way, 0);
    check("lru no wb", obs_wb_cycles, 0);

    // Dirty writeback with 3-cycle memory delay
    do_reset();
    run_req(16'h0F00, 1, 16'h1000, 1, D1, 0);
    for (int i = 2; i < 5; i++) run_req(16'h0F00, 1, 16'h1000 * i, 0, {8{16'(i)}}, 0);
    run_req(16'h0F00, 1, 16'h6000, 0, D2, 3);
    check("wb addr", obs_wb_addr, 16'h1000);
    check("wb cycles", obs_wb_cycles, 4);
    check("wb load way", obs_load_way, 0);
    check("wb resp cycle", obs_resp_cyc, 7);

    // Hit with evictee swaps into the hit way
    do_reset();
    run_req(16'h0F00, 1, 16'h1000, 0, D1, 0);
    run_req(16'h0F00, 1, 16'h2000, 0, E2, 0);
    run_req(16'h0F00, 1, 16'hAAA0, 1, D2, 0);
    run_req(16'hAAA0, 1, 16'hBBB0, 0, E2 ^ D1, 0);
    check("swap hit", obs_hit, 1);
    check("swap hit_dirty", obs_hit_dirty, 1);
    check("swap rdata", obs_rdata, D2);
    check("swap load way", obs_load_way, 2);
    check("swap no wb", obs_wb_cycles, 0);

    // Hit without evictee invalidates the way
    run_req(16'h2000, 0, 16'h0, 0, '0, 0);
    check("take hit", obs_hit, 1);
    check("take rdata", obs_rdata, E2);
    run_req(16'h2000, 0, 16'h0, 0, '0, 0);
    check("retake miss", obs_hit, 0);

    // Reset while in WRITEBACK
    do_reset();
    run_req(16'h0F00, 1, 16'h1000, 1, D1, 0);
    for (int i = 2; i < 5; i++) run_req(16'h0F00, 1, 16'h1000 * i, 0, D2, 0);
    l1_addr = 16'h0F00; l1_evict_valid = 1'b1; l1_evict_addr = 16'h6000;
    l1_evict_dirty = 1'b0; l1_evict_data = E2; l1_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    check("pre-reset pmem_write", pmem_write, 1);
    reset = 1'b1;
    #1;
    check("mid-reset pmem_write", pmem_write, 0);
    check("mid-reset dar_load", dar_load, 0);
    l1_req = 1'b0; l1_evict_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("mid-reset l1_resp", l1_resp, 0);
    end
    reset = 1'b0;
    model_reset();
    run_req(16'h1000, 0, 16'h0, 0, '0, 0);
    check("after reset miss", obs_hit, 0);

    // Random traffic over a small tag pool to force hits, matches and evictions
    do_reset();
    for (int n = 0; n < 250; n++) begin
      ra = {12'h100 + 12'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
      do ea = {12'h100 + 12'($urandom_range(0, 5)), 4'h0}; while (ea[15:4] == ra[15:4]);
      run_req(ra, $urandom_range(0, 3) != 0, ea, 1'($urandom_range(0, 1)),
              {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/victim_cache_ctrl.md
Name: victim_cache_ctrl

Overview:
Control and tag/LRU block for the 4-entry fully-associative victim cache.
- Sits between the L1 cache controller (upstream) and physical memory (downstream).
- Drives the victim-cache data array: load, way, data_in. Consumes that array's four burst outputs.
- On an L1 miss it looks up the missing line, swaps in the L1 evictee, and writes back dirty victim-cache evictions to memory.

Parameters:
TAG_WIDTH, 12, line tag width (address[15:4])
OFFSET_BITS, 4, byte offset within a 128-bit burst

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
l1_req  in  1  lookup request; held high with all l1_* inputs stable until l1_resp
l1_addr  in  16  address of missing line
l1_evict_valid  in  1  request carries an L1 evictee
l1_evict_addr  in  16  evictee address
l1_evict_dirty  in  1  evictee dirty
l1_evict_data  in  128  evictee burst
l1_resp  out  1  one-cycle completion pulse
l1_hit  out  1  valid with l1_resp; line found
l1_hit_dirty  out  1  dirty bit of returned line
l1_rdata  out  128  returned burst, valid with l1_resp
dar_load  out  1  data array write enable
dar_way  out  2  data array way select
dar_data_in  out  128  data array write data
dar_out_a..dar_out_d  in  128 each  data array way outputs
pmem_write  out  1  memory write request, held until pmem_resp
pmem_address  out  16  {tag, 4'b0}
pmem_wdata  out  128  writeback burst
pmem_resp  in  1  memory write done

Behaviour:
- Reset (async):
  - state=IDLE; valid[3:0]=0; dirty[3:0]=0.
  - LRU ages A..D = 0,1,2,3.
  - All outputs 0; response registers 0.
  - Data array is not cleared.
  - Reset mid-operation: pending pmem_write dropped, no l1_resp; L1 reissues the request.
- States: IDLE, CHECK, WRITEBACK, INSERT, RESPOND.
- IDLE:
  - On l1_req=1, go to CHECK.
  - Inputs are not latched; L1 holds them stable.
- CHECK (one cycle):
  - hit = any valid way with tag == l1_addr[15:4]; hit_way = lowest-index match.
  - Latch l1_rdata = mux(dar_out, hit_way), l1_hit, l1_hit_dirty. On miss, rdata=0 and dirty=0.
  - Slot selection, in priority order:
    1. If l1_evict_valid and hit: slot = hit_way (swap).
    2. Else if the evictee tag matches a valid way: slot = that way, no writeback.
    3. Else: slot = lowest-index invalid way, otherwise the way with age 3.
  - Next state:
    - Hit and !l1_evict_valid: clear valid[hit_way], go to RESPOND.
    - !l1_evict_valid (miss): go to RESPOND.
    - Slot valid and dirty, not a hit slot, no tag match: go to WRITEBACK.
    - Otherwise: go to INSERT.
- WRITEBACK:
  - pmem_write=1; pmem_address = {tag[slot], 4'b0}; pmem_wdata = dar_out[slot].
  - Held stable until pmem_resp=1, then go to INSERT.
- INSERT (one cycle):
  - dar_load=1, dar_way=slot, dar_data_in=l1_evict_data.
  - Update tag[slot], valid=1, dirty[slot]=l1_evict_dirty.
  - slot becomes MRU. Go to RESPOND.
- RESPOND: l1_resp=1 for exactly one cycle, then go to IDLE. L1 must drop l1_req the following cycle.
- LRU rule: touched way age := 0; every way with age below the old age increments. Ages stay a permutation of 0..3.
  - A hit without an evictee does not age the other ways.
- Latency, counted from the first cycle l1_req is sampled in IDLE:
  - No evictee: l1_resp in cycle +2.
  - Evictee, no writeback: l1_resp in cycle +3.
  - Writeback: l1_resp in cycle 3 + (cycles to pmem_resp) + 1.
- dar_load is 1 only in INSERT. pmem_write is 1 only in WRITEBACK.
- l1_evict_addr tag equal to l1_addr tag is a protocol violation; behaviour is unspecified.

Decomposition:
- lc3b_types package:
  - lc3b_vc_tag (logic [11:0])
  - lc3b_vc_way (logic [1:0])
  - lc3b_vc_age (logic [1:0])
  - existing lc3b_burst / lc3b_word
- One sub-module: vc_lru. Holds the four age counters; inputs touch/way; outputs lru_way (age 3).

Test Plan:
- Empty cache, l1_req addr 0x1230, no evictee -> l1_resp at cycle +2, l1_hit=0, l1_rdata=0, no dar_load.
- Four inserts, evictees 0x1000/0x2000/0x3000/0x4000 clean -> ways 0,1,2,3 filled in order; fifth evictee 0x5000 clean -> replaces way 0 (LRU), no pmem_write.
- Way 0 holds dirty 0x1000, all ways valid, way 0 LRU, evictee 0x6000 -> pmem_write with address 0x1000 and way-0 data until pmem_resp (3-cycle delay), then dar_load way 0, then l1_resp.
- Hit: way 2 holds 0xAAA0 dirty with data D; request 0xAAA0 with evictee 0xBBB0 -> l1_hit=1, l1_hit_dirty=1, l1_rdata=D, dar_load way 2 with evictee data, no writeback.
- Hit without evictee -> line returned, valid[hit_way]=0; repeat request -> l1_hit=0.
- Reset asserted during WRITEBACK -> pmem_write drops immediately, valid=0, no l1_resp, next request behaves as from reset.
